// File: rtl/elastic_fifo.sv
// elastic_fifo: registered valid/ready elastic buffer with synchronous flush
module elastic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       data_in_valid,
    output logic                       data_in_ready,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_out_valid,
    input  logic                       data_out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    assign data_in_ready = occupancy != OW'(DEPTH);
    assign data_out_valid = occupancy != '0;
    assign data_out = mem[rd_ptr];
    assign push = data_in_valid & data_in_ready;
    assign pop = data_out_valid & data_out_ready;
    // pointers and fill count; reset and flush both empty the buffer, reset taking priority
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            occupancy <= occupancy + OW'(push) - OW'(pop);
        end
    end
    // storage has no reset; an entry is only visible once occupancy covers it
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end
endmodule

// File: tb/tb_elastic_fifo.sv
// tb_elastic_fifo: scoreboard bench for elastic_fifo at DEPTH=2 and DEPTH=3
module tb_elastic_fifo;
    localparam int N = 1000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear2 = 1'b0, clear3 = 1'b0;
    logic [31:0] din2 = '0, din3 = '0, dout2, dout3;
    logic in_valid2 = 1'b0, in_valid3 = 1'b0, in_ready2, in_ready3;
    logic out_valid2, out_valid3, out_ready2 = 1'b0, out_ready3 = 1'b0;
    logic [1:0] occ2, occ3;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp2[$];
    logic [31:0] exp3[$];
    logic hold2 = 1'b0, hold3 = 1'b0, pa2 = 1'b0, pa3 = 1'b0;
    logic [31:0] hd2 = '0, hd3 = '0, pd2 = '0, pd3 = '0;

    elastic_fifo #(.DATA_WIDTH(32), .DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2),
        .data_in(din2), .data_in_valid(in_valid2), .data_in_ready(in_ready2),
        .data_out(dout2), .data_out_valid(out_valid2), .data_out_ready(out_ready2),
        .occupancy(occ2)
    );

    elastic_fifo #(.DATA_WIDTH(32), .DEPTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .clear(clear3),
        .data_in(din3), .data_in_valid(in_valid3), .data_in_ready(in_ready3),
        .data_out(dout3), .data_out_valid(out_valid3), .data_out_ready(out_ready3),
        .occupancy(occ3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic monitor;
        forever begin
            @(negedge clk);
            if (hold2) begin
                chk("dut2 hold valid", out_valid2, 1);
                chk("dut2 hold data", dout2, hd2);
            end
            if (hold3) begin
                chk("dut3 hold valid", out_valid3, 1);
                chk("dut3 hold data", dout3, hd3);
            end
            hold2 = rst_n && !clear2 && out_valid2 && !out_ready2;
            hd2 = dout2;
            hold3 = rst_n && !clear3 && out_valid3 && !out_ready3;
            hd3 = dout3;
            if (rst_n && !clear2 && out_valid2 && out_ready2) begin
                if (exp2.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dut2 extra word: got 0x%h, none expected", dout2);
                end else chk("dut2 order", dout2, exp2.pop_front());
            end
            if (rst_n && !clear3 && out_valid3 && out_ready3) begin
                if (exp3.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dut3 extra word: got 0x%h, none expected", dout3);
                end else chk("dut3 order", dout3, exp3.pop_front());
            end
            if (pa2) assert (in_valid2 && din2 == pd2) else $error("dut2 upstream handshake broken");
            if (pa3) assert (in_valid3 && din3 == pd3) else $error("dut3 upstream handshake broken");
            pa2 = rst_n && !clear2 && in_valid2 && !in_ready2;
            pd2 = din2;
            pa3 = rst_n && !clear3 && in_valid3 && !in_ready3;
            pd3 = din3;
            if (rst_n) begin
                chk("dut2 occupancy bound", 32'(occ2 <= 2'd2), 1);
                chk("dut3 occupancy bound", 32'(occ3 <= 2'd3), 1);
            end
        end
    endtask

    task automatic driver;
        bit p2, p3, a2, a3;
        int s2, s3, cyc;
        // reset held with a word offered
        in_valid2 = 1'b1;
        din2 = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("reset occupancy", occ2, 0);
            chk("reset out_valid", out_valid2, 0);
            chk("reset in_ready", in_ready2, 1);
        end
        rst_n = 1'b1;
        exp2.push_back(32'hDEADBEEF);
        tick;
        in_valid2 = 1'b0;
        chk("post-reset accept", occ2, 1);
        out_ready2 = 1'b1;
        tick;
        chk("post-reset drain", occ2, 0);
        // single-cycle latency
        in_valid2 = 1'b1;
        din2 = 32'h11;
        exp2.push_back(32'h11);
        tick;
        in_valid2 = 1'b0;
        chk("latency out_valid", out_valid2, 1);
        chk("latency data", dout2, 32'h11);
        chk("latency occupancy", occ2, 1);
        tick;
        chk("latency drained occ", occ2, 0);
        chk("latency drained valid", out_valid2, 0);
        // back-pressure at full
        out_ready2 = 1'b0;
        in_valid2 = 1'b1;
        din2 = 32'hA;
        exp2.push_back(32'hA);
        exp2.push_back(32'hB);
        exp2.push_back(32'hC);
        tick;
        din2 = 32'hB;
        tick;
        din2 = 32'hC;
        chk("full occupancy", occ2, 2);
        chk("full in_ready", in_ready2, 0);
        tick;
        chk("full holds C out", occ2, 2);
        out_ready2 = 1'b1;
        #1;
        chk("full in_ready while popping", in_ready2, 0);
        tick;
        out_ready2 = 1'b0;
        chk("after pop occupancy", occ2, 1);
        chk("after pop in_ready", in_ready2, 1);
        tick;
        in_valid2 = 1'b0;
        chk("C accepted", occ2, 2);
        out_ready2 = 1'b1;
        tick;
        tick;
        chk("full drained", occ2, 0);
        // flush mid-stream
        out_ready2 = 1'b0;
        in_valid2 = 1'b1;
        din2 = 32'h5;
        tick;
        din2 = 32'h6;
        tick;
        chk("pre-clear occupancy", occ2, 2);
        clear2 = 1'b1;
        din2 = 32'h7;
        out_ready2 = 1'b1;
        tick;
        clear2 = 1'b0;
        in_valid2 = 1'b0;
        chk("clear occupancy", occ2, 0);
        chk("clear out_valid", out_valid2, 0);
        chk("clear in_ready", in_ready2, 1);
        exp2.push_back(32'h8);
        in_valid2 = 1'b1;
        din2 = 32'h8;
        tick;
        in_valid2 = 1'b0;
        chk("post-clear occupancy", occ2, 1);
        tick;
        chk("post-clear drained", occ2, 0);
        // streaming through a non-power-of-two depth
        out_ready3 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid3 = 1'b1;
            din3 = 32'(i);
            exp3.push_back(32'(i));
            chk("stream in_ready", in_ready3, 1);
            tick;
            chk("stream occupancy", occ3, 1);
        end
        in_valid3 = 1'b0;
        tick;
        chk("stream drained", occ3, 0);
        // random stalls on both buffers
        p2 = 0;
        p3 = 0;
        s2 = 0;
        s3 = 0;
        cyc = 0;
        while ((s2 < N || exp2.size() != 0 || s3 < N || exp3.size() != 0) && cyc < 20000) begin
            if (!p2 && s2 < N && $urandom_range(1) == 1) begin
                p2 = 1;
                din2 = $urandom;
                exp2.push_back(din2);
            end
            if (!p3 && s3 < N && $urandom_range(1) == 1) begin
                p3 = 1;
                din3 = $urandom;
                exp3.push_back(din3);
            end
            in_valid2 = p2;
            in_valid3 = p3;
            out_ready2 = $urandom_range(1) == 1;
            out_ready3 = $urandom_range(1) == 1;
            a2 = p2 && in_ready2;
            a3 = p3 && in_ready3;
            tick;
            cyc++;
            if (a2) begin
                p2 = 0;
                s2++;
            end
            if (a3) begin
                p3 = 0;
                s3++;
            end
        end
        in_valid2 = 1'b0;
        in_valid3 = 1'b0;
        out_ready2 = 1'b0;
        out_ready3 = 1'b0;
        chk("random within budget", 32'(cyc < 20000), 1);
        chk("random dut2 drained", occ2, 0);
        chk("random dut3 drained", occ3, 0);
        chk("dut2 words left", exp2.size(), 0);
        chk("dut3 words left", exp3.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            driver();
            begin
                repeat (50000) @(posedge clk);
                miscompares++;
                $display("FAIL watchdog: got 50000 cycles, expected completion sooner");
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/elastic_fifo.md
Name: elastic_fifo

Overview:
- Elastic buffer on each CGRA processing-element input, directly downstream of the input-select mux.
- Captures the mux output under a valid/ready handshake and decouples producer and consumer timing.
- Registered storage with registered ready:
  - no combinational path from data_out_ready to data_in_ready;
  - no combinational path from data_in to data_out.
- Supports synchronous flush from the configuration controller between kernels.

Parameters:
- DATA_WIDTH, 32, width of each stored word (matches mux output width).
- DEPTH, 2, number of entries; any integer >= 2 (not restricted to powers of two).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous flush; empties the buffer, same effect on state as reset.
- data_in  input  DATA_WIDTH  word from the upstream mux.
- data_in_valid  input  1  upstream word valid.
- data_in_ready  output  1  buffer can accept a word this cycle.
- data_out  output  DATA_WIDTH  head-of-queue word.
- data_out_valid  output  1  data_out holds a valid word.
- data_out_ready  input  1  downstream consumes the head word this cycle.
- occupancy  output  $clog2(DEPTH+1)  number of stored words.

Behaviour:
- Reset (rst_n=0 at rising edge):
  - write/read pointers = 0, occupancy = 0, data_out_valid = 0, data_in_ready = 1.
  - Storage contents are not reset.
  - data_out is don't-care while data_out_valid=0; the bench must not check it then.
- Outputs:
  - data_in_ready = (occupancy != DEPTH), derived only from registered state.
  - data_out_valid = (occupancy != 0).
  - data_out = storage[read pointer].
- Push = data_in_valid & data_in_ready. Pop = data_out_valid & data_out_ready.
- Push writes data_in to storage[write pointer]. Write pointer increments, wrapping DEPTH-1 -> 0.
- Pop increments the read pointer, wrapping DEPTH-1 -> 0.
- Occupancy update:
  - +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
- Latency:
  - Word pushed at edge k appears on data_out with data_out_valid=1 in the cycle after edge k, if the buffer was empty. No fall-through.
  - Minimum in-to-out latency is 1 cycle.
  - Throughput is 1 word/cycle in steady state when DEPTH >= 2.
- Full (occupancy=DEPTH):
  - data_in_ready=0, even if data_out_ready=1 in the same cycle. A pop frees space only from the next cycle.
  - data_in_valid is ignored.
- Empty (occupancy=0):
  - data_out_valid=0, so no pop occurs.
  - A push in the same cycle makes occupancy 1 next cycle.
- Simultaneous push/pop with 0<occupancy<DEPTH:
  - Both take effect and occupancy holds.
  - Read and write pointers never collide, since occupancy >= 1.
- Priority: rst_n=0 overrides clear, and clear overrides push/pop. Push/pop in a clear cycle are discarded.
- Reset or clear mid-stream: all stored words are dropped. Next cycle outputs equal the reset values.
- Ordering: strict FIFO. Words are output in push order with no loss or duplication.
- Upstream protocol requirement (assertion in bench): once data_in_valid=1 with data_in_ready=0, data_in_valid stays 1 and data_in stays stable until push.
- Downstream may deassert data_out_ready arbitrarily. data_out and data_out_valid hold stable while not popped.

Test Plan:
- Reset: drive data_in_valid=1, data_in=0xDEADBEEF with rst_n=0 for 2 cycles -> occupancy=0, data_out_valid=0, data_in_ready=1 throughout; after release, word is accepted on the first cycle.
- Latency: empty buffer, push 0x00000011 at edge k with data_out_ready=1 -> data_out=0x00000011 and data_out_valid=1 in cycle k+1, popped at edge k+1, occupancy back to 0.
- Full/back-pressure: DEPTH=2, data_out_ready=0, offer 0xA, 0xB, 0xC -> 0xA, 0xB accepted, occupancy=2, data_in_ready=0, 0xC held. Then data_out_ready=1 for one cycle -> 0xA popped, data_in_ready=0 that cycle, 0xC accepted the following cycle. Output order 0xA, 0xB, 0xC.
- Streaming/wrap: DEPTH=3, continuous valid and ready, push 1..10 -> one word/cycle after the first, output sequence 1..10, pointers wrap 3 times, occupancy stays at 1.
- Random stall: 1000 random words with random data_in_valid and data_out_ready (50% each) -> scoreboard matches in order, occupancy never exceeds DEPTH, handshake stability assertions pass.
- Clear mid-stream: occupancy=2 with 0x5, 0x6 stored, assert clear with a simultaneous push of 0x7 -> next cycle occupancy=0, data_out_valid=0; next push 0x8 is the first word out.
